// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - Shared key indices and attack FSM state type.
package button_conditioner_pkg;

  localparam int KEY_RIGHT  = 0;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_JUMP   = 2;
  localparam int KEY_SQUAT  = 3;
  localparam int KEY_ATTACK = 4;
  localparam int KEY_DEFEND = 5;
  localparam int KEY_SELECT = 6;
  localparam int NUM_KEYS   = 7;

  typedef enum logic {
    ATK_IDLE,
    ATK_COOL
  } atk_state_t;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// rtl/button_conditioner_debounce_channel.sv - One key: 2-FF sync, inversion to pressed=1, debounce.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  assign pressed  = ~sync2_q;
  assign stable_o = stable_q;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (pressed != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - Key front end: debounce, edge detect, play gating, attack cooldown.
// Held-attack repeat is compiled in with BUTTON_CONDITIONER_AUTOFIRE_EN.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_CYCLES = 12500000,
  parameter int AUTOFIRE_PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_key_n,
  input  logic       i_is_gaming,
  output logic       o_right,
  output logic       o_left,
  output logic       o_jump,
  output logic       o_squat,
  output logic       o_attack,
  output logic       o_defend,
  output logic       o_select,
  output logic       o_cooldown_busy
);

  localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);

  logic [NUM_KEYS-1:0] stable;
  logic                prev_jump_q, prev_atk_q, prev_sel_q;
  logic                jump_rise, atk_rise, sel_rise;
  logic                o_jump_q, o_select_q, o_attack_q, busy_q;
  atk_state_t          atk_state_q;
  logic [CDW-1:0]      cd_cnt_q;
  logic                fire_idle, fire_cool_end, atk_fire;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n_i (i_key_n[g]),
      .stable_o(stable[g])
    );
  end

  assign jump_rise = stable[KEY_JUMP]   & ~prev_jump_q;
  assign atk_rise  = stable[KEY_ATTACK] & ~prev_atk_q;
  assign sel_rise  = stable[KEY_SELECT] & ~prev_sel_q;

  // Opposing directions cancel rather than prioritise.
  assign o_right = stable[KEY_RIGHT] & ~stable[KEY_LEFT] & i_is_gaming;
  assign o_left  = stable[KEY_LEFT] & ~stable[KEY_RIGHT] & i_is_gaming;
  assign o_squat  = stable[KEY_SQUAT]  & i_is_gaming;
  assign o_defend = stable[KEY_DEFEND] & i_is_gaming;

  assign o_jump          = o_jump_q;
  assign o_select        = o_select_q;
  assign o_attack        = o_attack_q;
  assign o_cooldown_busy = busy_q;

`ifdef BUTTON_CONDITIONER_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_PERIOD + 1);

  logic [AW-1:0] af_cnt_q;
  logic          af_held, af_due;

  assign af_held = stable[KEY_ATTACK] & i_is_gaming;
  // Saturates once due so a repeat blocked by cooldown fires as soon as allowed.
  assign af_due  = af_held & (af_cnt_q == AW'(AUTOFIRE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt_q <= '0;
    end else if (!af_held || atk_fire) begin
      af_cnt_q <= '0;
    end else if (!af_due) begin
      af_cnt_q <= af_cnt_q + 1'b1;
    end
  end

  assign fire_idle     = atk_rise | af_due;
  assign fire_cool_end = af_due;
`else
  logic unused_af;

  assign unused_af     = ^AUTOFIRE_PERIOD;
  assign fire_idle     = atk_rise;
  assign fire_cool_end = 1'b0;
`endif

  assign atk_fire = i_is_gaming &
                    (((atk_state_q == ATK_IDLE) & fire_idle) |
                     ((atk_state_q == ATK_COOL) & (cd_cnt_q == '0) & fire_cool_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_jump_q <= 1'b0;
      prev_atk_q  <= 1'b0;
      prev_sel_q  <= 1'b0;
      o_jump_q    <= 1'b0;
      o_select_q  <= 1'b0;
    end else begin
      prev_jump_q <= stable[KEY_JUMP];
      prev_atk_q  <= stable[KEY_ATTACK];
      prev_sel_q  <= stable[KEY_SELECT];
      o_jump_q    <= jump_rise & i_is_gaming & ~stable[KEY_SQUAT];
      o_select_q  <= sel_rise;
    end
  end

  // Rises seen while cooling down, including the cycle of return to idle, are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atk_state_q <= ATK_IDLE;
      cd_cnt_q    <= '0;
      o_attack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (!i_is_gaming) begin
      atk_state_q <= ATK_IDLE;
      cd_cnt_q    <= '0;
      o_attack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      o_attack_q <= atk_fire;
      case (atk_state_q)
        ATK_IDLE: begin
          if (atk_fire) begin
            cd_cnt_q    <= CDW'(COOLDOWN_CYCLES - 1);
            atk_state_q <= ATK_COOL;
            busy_q      <= 1'b1;
          end
        end
        ATK_COOL: begin
          if (atk_fire) begin
            cd_cnt_q <= CDW'(COOLDOWN_CYCLES - 1);
          end else if (cd_cnt_q == '0) begin
            atk_state_q <= ATK_IDLE;
            busy_q      <= 1'b0;
          end else begin
            cd_cnt_q <= cd_cnt_q - 1'b1;
          end
        end
        default: atk_state_q <= ATK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - Scoreboard bench for button_conditioner (debounce 4, cooldown 10, autofire 6).
module tb_button_conditioner;

  localparam int D = 4;
  localparam int C = 10;
  localparam int A = 6;

  localparam logic [6:0] REL = 7'h7f;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] key_n = 7'h7f;
  logic       gaming = 1'b0;
  logic       o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select, o_cooldown_busy;
  logic [7:0] outs;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int q_jump[$];
  int q_atk[$];
  int q_sel[$];
  int t;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .COOLDOWN_CYCLES(C),
    .AUTOFIRE_PERIOD(A)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_key_n        (key_n),
    .i_is_gaming    (gaming),
    .o_right        (o_right),
    .o_left         (o_left),
    .o_jump         (o_jump),
    .o_squat        (o_squat),
    .o_attack       (o_attack),
    .o_defend       (o_defend),
    .o_select       (o_select),
    .o_cooldown_busy(o_cooldown_busy)
  );

  assign outs = {o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select, o_cooldown_busy};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 1ns after the edge that makes cyc == t0.
  task automatic go(input int t0);
    while (cyc < t0) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] press(input logic [6:0] base, input int bit_idx);
    logic [6:0] k;
    k = base;
    k[bit_idx] = 1'b0;
    return k;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_jump) begin
        if (q_jump.size() == 0) check("jump_unexpected", o_jump, 0);
        else check("jump_cycle", cyc, q_jump.pop_front());
      end
      if (o_attack) begin
        if (q_atk.size() == 0) check("attack_unexpected", o_attack, 0);
        else check("attack_cycle", cyc, q_atk.pop_front());
      end
      if (o_select) begin
        if (q_sel.size() == 0) check("select_unexpected", o_select, 0);
        else check("select_cycle", cyc, q_sel.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gaming = 1'b1;
    go(2);
    check("reset_outs", outs, 0);
    rst_n = 1'b1;
    go(8);
    check("idle_outs", outs, 0);

    // Single jump: pulse 7 cycles after raw edge, none while held.
    t = cyc + 1;
    go(t); key_n = press(REL, 2); q_jump.push_back(t + 7);
    go(t + 25); key_n = REL;
    go(t + 40);

    // Bounce 3 low / 1 high / 3 low is rejected, then exactly D low cycles is accepted.
    t = cyc + 1;
    go(t);      key_n = press(REL, 4);
    go(t + 3);  key_n = REL;
    go(t + 4);  key_n = press(REL, 4);
    go(t + 7);  key_n = REL;
    go(t + 20); check("bounce_busy", o_cooldown_busy, 0);
    key_n = press(REL, 4); q_atk.push_back(t + 27);
    go(t + 24); key_n = REL;
    go(t + 45);

    // Second press lands on the return-to-idle cycle and is dropped; third is accepted.
    t = cyc + 1;
    go(t);      key_n = press(REL, 4); q_atk.push_back(t + 7);
    go(t + 5);  key_n = REL;
    go(t + 6);  check("busy_before", o_cooldown_busy, 0);
    go(t + 7);  check("busy_start", o_cooldown_busy, 1);
    go(t + 10); key_n = press(REL, 4);
    go(t + 15); key_n = REL;
    go(t + 16); check("busy_last", o_cooldown_busy, 1);
    go(t + 17); check("busy_end", o_cooldown_busy, 0);
    go(t + 25); key_n = press(REL, 4); q_atk.push_back(t + 32);
    go(t + 30); key_n = REL;
    go(t + 32); check("busy_third", o_cooldown_busy, 1);
    go(t + 50);

    // Right and left together cancel; releasing left restores right 6 cycles later.
    t = cyc + 1;
    go(t);      key_n = press(press(REL, 0), 1);
    go(t + 12); check("both_right", o_right, 0);
    check("both_left", o_left, 0);
    key_n = press(REL, 0);
    go(t + 17); check("right_early", o_right, 0);
    go(t + 18); check("right_after", o_right, 1);
    check("left_after", o_left, 0);
    go(t + 20); key_n = REL;
    go(t + 35);

    // Squat held suppresses the jump pulse.
    t = cyc + 1;
    go(t);      key_n = press(REL, 3);
    go(t + 8);  check("squat_level", o_squat, 1);
    key_n = press(press(REL, 3), 2);
    go(t + 25); key_n = REL;
    go(t + 40);

    // Outside play only select pulses; defend level follows the gate.
    t = cyc + 1;
    go(t);
    gaming = 1'b0;
    key_n = press(press(press(press(REL, 6), 5), 4), 2);
    q_sel.push_back(t + 7);
    go(t + 12); check("nogame_outs", {o_right, o_left, o_squat, o_defend, o_cooldown_busy}, 0);
    key_n = press(REL, 5);
    go(t + 25); check("defend_gated", o_defend, 0);
    gaming = 1'b1;
    #1;
    check("defend_play", o_defend, 1);
    go(t + 26); key_n = REL;
    go(t + 40);

    // Reset during cooldown clears everything immediately.
    t = cyc + 1;
    go(t);      key_n = press(REL, 4); q_atk.push_back(t + 7);
    go(t + 5);  key_n = REL;
    go(t + 10); check("busy_pre_reset", o_cooldown_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", outs, 0);
    go(t + 13); rst_n = 1'b1;
    go(t + 14); check("post_reset_busy", o_cooldown_busy, 0);
    go(t + 30);

`ifdef BUTTON_CONDITIONER_AUTOFIRE_EN
    // Held attack repeats, spaced by the longer cooldown.
    t = cyc + 1;
    go(t);      key_n = press(REL, 4);
    q_atk.push_back(t + 7);
    q_atk.push_back(t + 17);
    q_atk.push_back(t + 27);
    q_atk.push_back(t + 37);
    go(t + 40); key_n = REL;
    go(t + 65);

    t = cyc + 1;
    go(t);      key_n = press(REL, 4); q_atk.push_back(t + 7);
    go(t + 12); check("af_busy", o_cooldown_busy, 1);
    rst_n = 1'b0;
    #1;
    check("af_reset_outs", outs, 0);
    go(t + 14); key_n = REL; rst_n = 1'b1;
    go(t + 30);
`endif

    go(cyc + 20);
    check("jump_pending", q_jump.size(), 0);
    check("attack_pending", q_atk.size(), 0);
    check("select_pending", q_sel.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the game controller.
- Takes the seven raw active-low board keys and switches, and produces the clean control strobes and levels that the game FSM consumes: right, left, jump, squat, attack, defend, select.
- Per channel it does a 2-FF synchroniser, then a debounce filter, then edge detection.
- It also applies game-level rules: left/right conflict, attack fire-rate cooldown, and gating outside play.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- COOLDOWN_CYCLES, 12500000: cycles after an accepted attack during which further attacks are dropped.
- AUTOFIRE_PERIOD, 25000000: repeat interval for held attack. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_key_n  in  7  raw keys, active-low. Bit 0 right, 1 left, 2 jump, 3 squat, 4 attack, 5 defend, 6 select.
- i_is_gaming  in  1  high while the game is in the play state
- o_right  out  1  level, move right
- o_left  out  1  level, move left
- o_jump  out  1  one-cycle pulse
- o_squat  out  1  level
- o_attack  out  1  one-cycle pulse
- o_defend  out  1  level
- o_select  out  1  one-cycle pulse
- o_cooldown_busy  out  1  high while an attack is blocked by cooldown

Behaviour:
- Clock and reset: clk is the clock; rst_n is the reset, asynchronous and active-low.
- All registers and outputs reset to 0. The synchroniser flops reset to 1, i.e. released.
- Synchroniser and inversion:
  - Each bit passes through a 2-FF synchroniser and is then inverted, so internally pressed = 1.
- Debounce, per channel:
  - Holds stable_r and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When sync == stable_r, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, stable_r takes sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
  - Latency: a raw edge reaches stable_r 2+DEBOUNCE_CYCLES cycles after the raw change.
- Edge detection:
  - prev_r tracks stable_r; rise = stable_r & ~prev_r.
  - A key held through reset produces one rise after debounce. This is intended.
- Levels:
  - o_right = stable_right & ~stable_left & i_is_gaming.
  - o_left = stable_left & ~stable_right & i_is_gaming.
  - Both held gives neither output.
  - o_squat and o_defend = stable level & i_is_gaming.
- o_jump:
  - Registered rise of jump, gated by i_is_gaming.
  - Suppressed if stable_squat is 1 in the same cycle.
- o_select:
  - Registered rise of select, never gated (it is used in the start, win and lose states).
- Attack FSM, states IDLE and COOL:
  - IDLE: on attack rise with i_is_gaming, o_attack pulses for 1 cycle; load cd_cnt = COOLDOWN_CYCLES-1; go to COOL.
  - COOL: o_cooldown_busy = 1. Attack rises are discarded, not queued.
  - COOL: cd_cnt decrements; at 0, go to IDLE. Busy is therefore high for exactly COOLDOWN_CYCLES cycles.
  - A rise arriving in the same cycle the FSM returns to IDLE is dropped. Rises are accepted from the next cycle.
  - i_is_gaming low forces IDLE, clears cd_cnt, and holds o_attack at 0.
- Outputs are registered: pulse outputs appear one cycle after the internal rise.
- Asserting rst_n low mid-operation clears everything immediately, including in-flight debounce counts and cooldown.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOFIRE_EN.
- With the macro defined: while stable_attack stays 1 and i_is_gaming = 1, a further o_attack pulse fires every AUTOFIRE_PERIOD cycles, measured from the previous pulse. Cooldown still applies; if AUTOFIRE_PERIOD < COOLDOWN_CYCLES, the repeat waits for IDLE. Release resets the repeat counter.
- Without the macro: only rises fire; the repeat counter is not instantiated.

Decomposition:
- Shared game package:
  - Key index constants KEY_RIGHT..KEY_SELECT (0..6).
  - Key count NUM_KEYS = 7.
  - Attack FSM enum atk_state_t {ATK_IDLE, ATK_COOL}.
- Sub-module debounce_channel: 2-FF sync, inversion, counter, and stable_r output, parameterised by DEBOUNCE_CYCLES. Instantiated 7 times via generate.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10, AUTOFIRE_PERIOD=6):
- Reset with all keys released; press jump (bit 2 low) with i_is_gaming=1 → exactly one o_jump pulse, arriving 7 cycles after the raw edge; no further pulse while held.
- Bounce: attack low 3 cycles, high 1, low 3 → no o_attack. Then hold low ≥4 cycles → one pulse.
- Right and left both held → o_right=0, o_left=0. Release left → o_right=1 after 6 cycles.
- Two attack presses 5 cycles apart → first pulses, busy high for 10 cycles, second dropped. A third press after busy falls → pulses.
- i_is_gaming=0: press select → o_select pulses; press jump, attack or defend → all outputs stay 0.
- With autofire: hold attack 40 cycles → pulses spaced 10 cycles apart (cooldown dominates). Assert rst_n low mid-hold → all outputs 0 immediately.
